// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_pkg
// Description : Shared limits and elaboration helpers for DSP48A1 datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_pkg;

  localparam int DSP_MAX_WIDTH = 48;
  localparam int DSP_MAX_DEPTH = 8;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

  // Tap-select width must encode 0..depth and never collapse to zero bits.
  function automatic int tap_width(input int depth);
    return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
  endfunction

  function automatic bit cfg_ok(input int width, input int depth);
    return (width >= 1) && (width <= DSP_MAX_WIDTH) &&
           (depth >= 0) && (depth <= DSP_MAX_DEPTH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : dsp_pipe_stage
// Description : One data+valid pipeline register with ce, valid-only flush and sync reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_pipe_stage #(
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              valid_q;
  logic              valid_d;

  // Flush only kills the qualifier; the data word still advances with ce.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (ce) begin
      data_d  = data_i;
      valid_d = valid_i;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/dsp_pipe_delay.sv
`default_nettype none
// ============================================================================
// Module      : dsp_pipe_delay
// Description : DEPTH-stage delay line with runtime tap select, valid tracking and fill status.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_pipe_delay
  import dsp_pkg::*;
#(
  parameter  int WIDTH   = 18,
  parameter  int DEPTH   = 2,
  parameter  bit OUT_REG = 1'b0,
  localparam int TAP_W   = tap_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             primed
);

  if (!cfg_ok(WIDTH, DEPTH)) begin : g_cfg_check
    $error("dsp_pipe_delay: WIDTH=%0d DEPTH=%0d outside supported range", WIDTH, DEPTH);
  end

  // Entry 0 is the live input so that tap 0 and tap k share one index space.
  logic [DEPTH:0][WIDTH-1:0] stg_data;
  logic [DEPTH:0]            stg_vld;
  logic [WIDTH-1:0]          tap_data;
  logic                      tap_vld;

  assign stg_data[0] = in;
  assign stg_vld[0]  = in_valid;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    dsp_pipe_stage #(
      .DATA_W (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .ce      (ce),
      .flush   (flush),
      .data_i  (stg_data[k-1]),
      .valid_i (stg_vld[k-1]),
      .data_o  (stg_data[k]),
      .valid_o (stg_vld[k])
    );
  end

  if (DEPTH == 0) begin : g_passthru
    logic unused_ctrl;
    assign unused_ctrl = ^{tap_sel, flush, clk, rst, ce};
    assign tap_data    = stg_data[0];
    assign tap_vld     = stg_vld[0];
    assign primed      = 1'b1;
  end else begin : g_tapped
    logic [TAP_W-1:0] tap_eff;
    logic [TAP_W-1:0] fill_q;
    logic [TAP_W-1:0] fill_d;

    assign tap_eff = (tap_sel > TAP_W'(DEPTH)) ? TAP_W'(DEPTH) : tap_sel;

    always_comb begin
      tap_data = stg_data[0];
      tap_vld  = stg_vld[0];
      for (int k = 1; k <= DEPTH; k++) begin
        if (tap_eff == TAP_W'(k)) begin
          tap_data = stg_data[k];
          tap_vld  = stg_vld[k];
        end
      end
    end

    // Counts enabled shifts since the last rst/flush, saturating at DEPTH.
    always_comb begin
      fill_d = fill_q;
      if (flush) begin
        fill_d = '0;
      end else if (ce && (fill_q != TAP_W'(DEPTH))) begin
        fill_d = fill_q + TAP_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        fill_q <= '0;
      end else begin
        fill_q <= fill_d;
      end
    end

    assign primed = (fill_q == TAP_W'(DEPTH));
  end

  if (OUT_REG) begin : g_out_reg
    dsp_pipe_stage #(
      .DATA_W (WIDTH)
    ) u_out_reg (
      .clk     (clk),
      .rst     (rst),
      .ce      (ce),
      .flush   (1'b0),
      .data_i  (tap_data),
      .valid_i (tap_vld),
      .data_o  (out),
      .valid_o (out_valid)
    );
  end else begin : g_out_comb
    assign out       = tap_data;
    assign out_valid = tap_vld;
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_pipe_delay.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_pipe_delay
// Description : Directed bench for dsp_pipe_delay across four configurations sharing one stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_pipe_delay;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst;
  logic         ce;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] din;
  logic [2:0]   tap;

  logic [W-1:0] a_out, b_out, c_out, d_out;
  logic         a_v, b_v, c_v, d_v;
  logic         a_p, b_p, c_p, d_p;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // A: DEPTH=3 comb out; B: DEPTH=3 registered out; C: DEPTH=0 registered; D: DEPTH=5 comb.
  dsp_pipe_delay #(.WIDTH(W), .DEPTH(3), .OUT_REG(1'b0)) u_a (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in(din), .in_valid(in_valid),
    .tap_sel(tap[1:0]), .out(a_out), .out_valid(a_v), .primed(a_p));
  dsp_pipe_delay #(.WIDTH(W), .DEPTH(3), .OUT_REG(1'b1)) u_b (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in(din), .in_valid(in_valid),
    .tap_sel(tap[1:0]), .out(b_out), .out_valid(b_v), .primed(b_p));
  dsp_pipe_delay #(.WIDTH(W), .DEPTH(0), .OUT_REG(1'b1)) u_c (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in(din), .in_valid(in_valid),
    .tap_sel(tap[0]), .out(c_out), .out_valid(c_v), .primed(c_p));
  dsp_pipe_delay #(.WIDTH(W), .DEPTH(5), .OUT_REG(1'b0)) u_d (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in(din), .in_valid(in_valid),
    .tap_sel(tap), .out(d_out), .out_valid(d_v), .primed(d_p));

  // Model: history of the last 8 accepted words (index = shifts ago), their
  // surviving valid flags, and the count of enabled shifts since rst/flush.
  logic [W-1:0] hd [1:8];
  logic         hv [1:8];
  int           n_shift;
  logic [W-1:0] rb_d, rc_d;
  logic         rb_v, rc_v;
  bit           model_ok = 1'b0;

  function automatic logic [W:0] tap_of(input int depth, input int t);
    int k;
    k = (t > depth) ? depth : t;
    if (k == 0) return {din, in_valid};
    return {hd[k], hv[k]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= 8; k++) begin
        hd[k] = '0;
        hv[k] = 1'b0;
      end
      n_shift  = 0;
      {rb_d, rb_v} = '0;
      {rc_d, rc_v} = '0;
      model_ok = 1'b1;
    end else begin
      if (ce) begin
        {rb_d, rb_v} = tap_of(3, int'(tap[1:0]));
        {rc_d, rc_v} = {din, in_valid};
        for (int k = 8; k >= 2; k--) begin
          hd[k] = hd[k-1];
          hv[k] = hv[k-1];
        end
        hd[1] = din;
        hv[1] = in_valid;
      end
      if (flush) begin
        for (int k = 1; k <= 8; k++) hv[k] = 1'b0;
        n_shift = 0;
      end else if (ce && n_shift < 8) begin
        n_shift = n_shift + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      chk("A.tap",    {a_out, a_v}, tap_of(3, int'(tap[1:0])));
      chk("A.primed", a_p,          n_shift >= 3);
      chk("B.reg",    {b_out, b_v}, {rb_d, rb_v});
      chk("B.primed", b_p,          n_shift >= 3);
      chk("C.reg",    {c_out, c_v}, {rc_d, rc_v});
      chk("C.primed", c_p,          1'b1);
      chk("D.tap",    {d_out, d_v}, tap_of(5, int'(tap)));
      chk("D.primed", d_p,          n_shift >= 5);
    end
  end

  task automatic step(input logic [W-1:0] d, input logic v, input logic c,
                      input logic f, input logic r, input logic [2:0] t);
    @(posedge clk);
    #2;
    din = d; in_valid = v; ce = c; flush = f; rst = r; tap = t;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; flush = 1'b0; in_valid = 1'b0; din = '0; tap = 3'd3;
    step(0, 0, 1, 0, 1, 3);
    step(0, 0, 1, 0, 1, 3);
    chk("rst.a_v", a_v, 1'b0);  chk("rst.a_p", a_p, 1'b0);
    chk("rst.b_out", b_out, 0); chk("rst.b_v", b_v, 1'b0);
    chk("rst.c_out", c_out, 0); chk("rst.c_p", c_p, 1'b1);

    // Basic stream, tap 3, continuous ce.
    step(1, 1, 1, 0, 0, 3); chk("s1.c0.a_v", a_v, 1'b0);
    step(2, 1, 1, 0, 0, 3); chk("s1.c1.c_out", {c_out, c_v}, {18'd1, 1'b1});
    step(3, 1, 1, 0, 0, 3); chk("s1.c2.a_p", a_p, 1'b0);
    step(4, 1, 1, 0, 0, 3); chk("s1.c3.a", {a_out, a_v, a_p}, {18'd1, 1'b1, 1'b1});
    step(0, 0, 1, 0, 0, 3); chk("s1.c4.a", a_out, 2); chk("s1.c4.b", {b_out, b_v}, {18'd1, 1'b1});
    step(0, 0, 1, 0, 0, 3); chk("s1.c5.a", a_out, 3);
    step(0, 0, 1, 0, 0, 3); chk("s1.c6.a", a_out, 4);
    step(0, 0, 1, 0, 0, 3); chk("s1.c7.a_v", a_v, 1'b0);

    // ce low for one cycle delays everything by one.
    step(0, 0, 1, 0, 1, 3);
    step(5, 1, 1, 0, 0, 3);
    step(99, 1, 0, 0, 0, 3);
    step(6, 1, 1, 0, 0, 3);
    step(7, 1, 1, 0, 0, 3); chk("s2.c3.a_p", a_p, 1'b0);
    step(8, 1, 1, 0, 0, 3); chk("s2.c4.a", {a_out, a_v, a_p}, {18'd5, 1'b1, 1'b1});
    step(9, 1, 1, 0, 0, 3); chk("s2.c5.a", a_out, 6);
    step(10, 1, 1, 0, 0, 3); chk("s2.c6.a", a_out, 7);

    // Flush mid-stream: data keeps moving, valids and fill restart.
    step(20, 1, 1, 0, 0, 3);
    step(21, 1, 1, 0, 0, 3);
    step(22, 1, 1, 1, 0, 3); chk("s4.f2.a_p", a_p, 1'b1);
    step(23, 1, 1, 0, 0, 3); chk("s4.f3.a", {a_out, a_v, a_p}, {18'd20, 1'b0, 1'b0});
    step(24, 1, 1, 0, 0, 3); chk("s4.f4.a_v", a_v, 1'b0);
    step(25, 1, 1, 0, 0, 3); chk("s4.f5.a", {a_v, a_p}, 2'b00);
    step(26, 1, 1, 0, 0, 3); chk("s4.f6.a", {a_out, a_v, a_p}, {18'd23, 1'b1, 1'b1});

    // rst together with flush, registered output latency 4.
    step(30, 1, 1, 0, 0, 3);
    step(31, 1, 1, 0, 0, 3);
    step(32, 1, 1, 1, 1, 3);
    step(40, 1, 1, 0, 0, 3); chk("s5.g3.b", {b_out, b_v, b_p}, {18'd0, 1'b0, 1'b0});
    chk("s5.g3.c", {c_out, c_v, c_p}, {18'd0, 1'b0, 1'b1});
    step(41, 1, 1, 0, 0, 3);
    step(42, 1, 1, 0, 0, 3);
    step(43, 1, 1, 0, 0, 3); chk("s5.g6.b_v", b_v, 1'b0); chk("s5.g6.a", {a_out, a_v}, {18'd40, 1'b1});
    step(44, 1, 1, 0, 0, 3); chk("s5.g7.b", {b_out, b_v}, {18'd40, 1'b1});

    // Tap clamp (7 on DEPTH=5) and bypass tap 0.
    for (int i = 0; i < 6; i++) step(W'(50 + i), 1, 1, 0, 0, 7);
    chk("s3.d_clamp", {d_out, d_v}, {18'd50, 1'b1});
    chk("s3.a_tap3",  {a_out, a_v}, {18'd52, 1'b1});
    step(18'h2A, 1, 1, 0, 0, 0);
    chk("s3.a_bypass", {a_out, a_v}, {18'h2A, 1'b1});
    chk("s3.d_bypass", {d_out, d_v}, {18'h2A, 1'b1});
    step(18'h2B, 0, 1, 0, 0, 0);
    chk("s3.a_bypass_nv", {a_out, a_v}, {18'h2B, 1'b0});
    step(0, 0, 0, 0, 0, 2);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dsp_pipe_delay.md
Name: dsp_pipe_delay

Overview:
Parametrised pipeline delay line for the DSP48A1 datapath. It replaces single optional-register-plus-bypass stages with a DEPTH-stage shift register. Features:
- a runtime tap select chooses how many stages the data passes through;
- each stage carries a valid bit;
- a fill counter reports when the line is primed;
- a flush input clears the valid bits and the fill counter.

Used on the A/B/C/D/M/P operand paths wherever the pipeline depth must be tunable without rebuilding.

Parameters:
WIDTH, 18, data width in bits (1..48).
DEPTH, 2, number of pipeline stages (0..8). 0 means combinational pass-through.
OUT_REG, 0, 1 adds one register after the tap mux, with the same ce and rst.
TAP_W, derived: clog2(DEPTH+1), minimum 1. Not user-overridable.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous active-high reset
ce  in  1  clock enable for all stages, the out register and the fill counter
flush  in  1  synchronous clear of valid bits and fill counter; data is kept
in  in  WIDTH  input data
in_valid  in  1  input qualifier
tap_sel  in  TAP_W  number of stages in the path (0 = bypass)
out  out  WIDTH  selected tap (registered if OUT_REG=1)
out_valid  out  1  valid bit of the selected tap
primed  out  1  high once DEPTH enabled shifts have occurred since the last rst/flush

Behaviour:
- Stage state: s[1..DEPTH] (WIDTH bits) and v[1..DEPTH] (1 bit each).
- Priority per cycle is rst > flush > ce > hold.
- rst:
  - s, v, the out register and fill_cnt all go to 0.
  - out=0, out_valid=0 and primed=0 from the next cycle. If DEPTH=0 and OUT_REG=0, out follows in combinationally.
- ce=1, no rst:
  - s[1]<=in; s[k]<=s[k-1] for k>1.
  - v[1]<=in_valid & ~flush; v[k]<=v[k-1] & ~flush.
- ce=0: all registers hold, including the out register and fill_cnt.
- flush=1 (no rst):
  - all v go to 0 and fill_cnt goes to 0, whether or not ce is high.
  - data registers shift only if ce=1, as above.
- fill_cnt:
  - width TAP_W; increments on ce when not flushed or reset; saturates at DEPTH.
  - primed = (fill_cnt == DEPTH).
  - DEPTH=0: primed is constant 1 and is not affected by rst.
- Tap mux (combinational):
  - tap_sel=0 selects {in, in_valid}; tap_sel=k selects {s[k], v[k]}.
  - tap_sel>DEPTH clamps to DEPTH.
  - DEPTH=0: tap_sel is ignored.
- OUT_REG=1: the mux result is registered with ce and rst (rst → 0).
- Latency from in to out, in enabled cycles, is tap_sel + OUT_REG.
- tap_sel may change on any cycle; the new path takes effect combinationally. There is no drain; the data already in the stages is kept.
- Reset mid-stream: all in-flight data is lost. out_valid stays 0 until new valid data has traversed the selected depth.

Decomposition:
- Shared package dsp_pkg holds:
  - function clog2;
  - DSP_MAX_WIDTH=48 and DSP_MAX_DEPTH=8;
  - elaboration checks (DEPTH<=DSP_MAX_DEPTH, WIDTH<=DSP_MAX_WIDTH).
- One sub-module is natural: dsp_pipe_stage, a single WIDTH+1 register with ce, flush and sync rst. Instantiate it DEPTH times in a generate loop, and reuse it for the OUT_REG register with flush tied to 0.

Test Plan:
- DEPTH=3, OUT_REG=0, tap_sel=3, ce=1: drive in=1,2,3,4 with in_valid=1 from cycle 0 → out=1 (valid) at cycle 3, then 2,3,4; primed rises at cycle 3.
- Same config, ce low on cycle 1 only → all outputs delayed by one cycle; data sequence intact; primed rises at cycle 4.
- tap_sel=0 → out==in and out_valid==in_valid in the same cycle. tap_sel=7 (>DEPTH) → behaves as tap_sel=3.
- Stream with flush=1 at cycle 2 and ce=1 → data keeps shifting; out_valid=0 for the next 3 cycles; primed drops, then re-rises 3 cycles later.
- rst and flush asserted together mid-stream with OUT_REG=1 → next cycle out=0, out_valid=0, primed=0. First new valid word appears at latency 3+1=4.
- DEPTH=0, OUT_REG=1 → out = in delayed one enabled cycle; primed constantly 1; rst clears out to 0.
